// File: rtl/pc_ctrl.sv
// Program sequencer for the fetch/PC block: launches a program, resolves
// JMP/BRZ against a registered zero flag, detects HALT and enforces a watchdog.
module pc_ctrl #(
    parameter logic [7:0]  START0     = 8'd0,
    parameter logic [7:0]  START1     = 8'd64,
    parameter logic [7:0]  START2     = 8'd128,
    parameter logic [7:0]  START3     = 8'd192,
    parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic [1:0]  Prog_Sel,
    input  logic [8:0]  Instr,
    input  logic        Zero,
    input  logic        Flag_Wr,
    output logic        Start,
    output logic [7:0]  Start_Addr,
    output logic        Branch,
    output logic [5:0]  Offset,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic [15:0] Cycle_Cnt
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned IMM_W = 6;
    localparam logic [OP_W-1:0] OP_JMP = 3'b101;
    localparam logic [OP_W-1:0] OP_BRZ = 3'b110;
    localparam logic [8:0]      HALT   = 9'h1FF;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;
    logic             flag_q;
    logic [1:0]       sel_q;
    logic [OP_W-1:0]  opcode;
    logic [IMM_W-1:0] imm;
    logic             is_halt;
    logic             wd_hit;
    logic [7:0]       start_sel;

    assign opcode  = Instr[8:6];
    assign imm     = Instr[5:0];
    assign is_halt = (Instr == HALT);
    assign wd_hit  = (Cycle_Cnt == (MAX_CYCLES - 16'd1));

    always_comb begin
        start_sel = START0;
        case (sel_q)
            2'd1:    start_sel = START1;
            2'd2:    start_sel = START2;
            2'd3:    start_sel = START3;
            default: start_sel = START0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; HALT has priority over the watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Req) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN:    if (is_halt || wd_hit) state_d = S_DONE;
            S_DONE:   if (!Req) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Run bookkeeping: program select, zero flag, instruction count, timeout
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sel_q     <= 2'd0;
            flag_q    <= 1'b0;
            Cycle_Cnt <= 16'd0;
            Timeout   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (Req) sel_q <= Prog_Sel;
                S_LAUNCH: begin
                    flag_q    <= 1'b0;
                    Cycle_Cnt <= 16'd0;
                    Timeout   <= 1'b0;
                end
                S_RUN: begin
                    Cycle_Cnt <= Cycle_Cnt + 16'd1;
                    if (Flag_Wr) flag_q <= Zero;
                    if (!is_halt && wd_hit) Timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: state decode plus branch decode of the current instruction
    always_comb begin
        Start      = 1'b0;
        Start_Addr = 8'd0;
        Branch     = 1'b0;
        Offset     = 6'd0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_q)
            S_LAUNCH: begin
                Start      = 1'b1;
                Start_Addr = start_sel;
                Busy       = 1'b1;
            end
            S_RUN: begin
                Busy = 1'b1;
                if (opcode == OP_JMP || (opcode == OP_BRZ && flag_q)) begin
                    Branch = 1'b1;
                    Offset = imm;
                end
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Drives the next-PC interface (Start, Start_Addr, Branch, Offset) of the fetch/PC block. It is the sequencing side of that interface.
- Launches a program at its start address and examines each fetched instruction word.
- Resolves conditional and unconditional branches against a registered zero flag.
- Detects HALT, counts executed instructions and enforces a watchdog timeout.
- Sits between the instruction ROM output, the ALU Zero output and the PC register.

Parameters:
- START0, 8'd0, start address for Prog_Sel = 0
- START1, 8'd64, start address for Prog_Sel = 1
- START2, 8'd128, start address for Prog_Sel = 2
- START3, 8'd192, start address for Prog_Sel = 3
- MAX_CYCLES, 16'd4096, watchdog limit in executed instructions (must be ≥ 2)

Ports:
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  request to run a program; level-sensitive
- Prog_Sel  in  2  program select, sampled in IDLE when Req is high
- Instr  in  9  instruction word at the current PC (combinational ROM output)
- Zero  in  1  ALU zero result
- Flag_Wr  in  1  capture Zero into the flag register this cycle
- Start  out  1  load Start_Addr into the PC
- Start_Addr  out  8  PC load value
- Branch  out  1  PC += Offset at the next edge
- Offset  out  6  two's-complement branch offset; the PC adder sign-extends it to 8 bits
- Busy  out  1  high in LAUNCH and RUN
- Done  out  1  high in DONE
- Timeout  out  1  high in DONE when the program ended by watchdog
- Cycle_Cnt  out  16  instructions executed in the current or last run

Behaviour:
- States: IDLE, LAUNCH, RUN, DONE.
- Reset (any state, including mid-RUN):
  - state = IDLE; flag_q = 0; Cycle_Cnt = 0; sel_q = 0; Timeout = 0.
  - All outputs are 0, Start_Addr = 8'd0.
- IDLE: if Req = 1, latch sel_q = Prog_Sel and go to LAUNCH; otherwise stay.
- LAUNCH (exactly 1 cycle):
  - Start = 1; Start_Addr = START[sel_q]; Branch = 0.
  - Clear flag_q, Cycle_Cnt and Timeout. Go to RUN.
- RUN (one instruction per cycle; Instr reflects the current PC):
  - Cycle_Cnt increments by 1 each RUN cycle.
  - Decode uses opcode = Instr[8:6] and imm = Instr[5:0].
  - Opcode 3'b101 (JMP): Branch = 1, Offset = imm.
  - Opcode 3'b110 (BRZ): Branch = flag_q, Offset = imm.
  - Any other opcode: Branch = 0, Offset = 6'd0.
  - Instr = 9'h1FF (HALT): Branch = 0; next state DONE, Timeout stays 0.
  - Watchdog: if Cycle_Cnt == MAX_CYCLES-1 and Instr is not HALT, next state DONE with Timeout set to 1. HALT wins when both occur in the same cycle.
  - Flag_Wr = 1: flag_q <= Zero at the edge. A BRZ in the same cycle uses the old flag_q (no bypass).
  - Req is ignored in RUN; a run cannot be aborted except by Reset.
  - Offset is 6'd0 whenever Branch = 0.
- DONE:
  - Done = 1; Timeout and Cycle_Cnt hold.
  - Branch = 0 and Start = 0 (the PC free-increments; harmless).
  - Req = 0 moves to IDLE. Cycle_Cnt and Timeout keep their values until the next LAUNCH.
- Branch and Start are never both high. Outputs are registered state plus combinational decode of Instr; there are no combinational paths from Zero to outputs.
- PC wrap-around is the PC block's concern. Offset is passed through unmodified.

Test Plan:
- Reset, then Req = 1 with Prog_Sel = 2 → one cycle with Start = 1, Start_Addr = 8'd128, then Busy = 1 and Cycle_Cnt counting 1, 2, 3.
- In RUN, Flag_Wr = 1 with Zero = 1, then next cycle Instr = {3'b110, 6'h3E} → Branch = 1, Offset = 6'h3E (−2). Repeat with Zero = 0 captured → Branch = 0, Offset = 0.
- Same cycle: Flag_Wr = 1, Zero = 1, Instr = BRZ while flag_q = 0 → Branch = 0; next-cycle BRZ → Branch = 1.
- Instr = {3'b101, 6'h05} → Branch = 1, Offset = 5 regardless of flag_q. Instr = 9'h1FF after 10 RUN cycles → Done = 1, Timeout = 0, Cycle_Cnt = 11; Req = 0 → IDLE.
- MAX_CYCLES = 8 with no HALT → DONE after 8 RUN cycles, Timeout = 1, Cycle_Cnt = 8. Variant with HALT on the 8th cycle → Timeout = 0.
- Reset asserted mid-RUN → next cycle state IDLE, all outputs 0, Cycle_Cnt = 0. Req held high → LAUNCH follows the next cycle.
